// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, access
// direction codes, port identifiers and default geometry.
package data_mem_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int ADDR_W_DFLT = 32;
  localparam int DEPTH_DFLT  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arbState_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Two-way round-robin picker. A sole requester always wins; on a tie the
// pointer decides. The pointer moves to the port that was not served each
// time a transaction finishes, so a losing requester waits at most one
// transaction.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  input  logic servedPort,
  output logic pick,
  output logic anyReq
);

  logic rrPtr_r;

  // Pointer register: favour the other port once a transaction has finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_r <= PORT0;
    end else if (advance) begin
      rrPtr_r <= ~servedPort;
    end else begin
      rrPtr_r <= rrPtr_r;
    end
  end

  // Winner selection from the current request pair and the pointer.
  always_comb begin
    pick   = PORT0;
    anyReq = req0 | req1;
    if (req0 && req1) begin
      pick = rrPtr_r;
    end else if (req1) begin
      pick = PORT1;
    end else begin
      pick = PORT0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the load/store stage (port 0)
// and the loader/debug port (port 1). One transaction is in flight at a time;
// the memory pins are held for MEM_LAT cycles and the read data is sampled on
// the last of them. Out-of-range indices never reach the memory and complete
// with err set. Every output is a register.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DEPTH   = DEPTH_DFLT,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              mem_active,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Widened by one bit so the unsigned compare is exact for any ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      LAT_LOAD  = 3'(MEM_LAT - 1);

  arbState_e         state_r, stateNext_s;
  logic [2:0]        latCnt_r, latCntNext_s;
  logic              capPort_r, capPortNext_s;
  logic              capErr_r, capErrNext_s;

  logic              gnt0Next_s, gnt1Next_s, done0Next_s, done1Next_s;
  logic              err0Next_s, err1Next_s;
  logic [DATA_W-1:0] rdata0Next_s, rdata1Next_s, readVal_s;
  logic              memActiveNext_s, memRwNext_s;
  logic [ADDR_W-1:0] memIndexNext_s;
  logic [DATA_W-1:0] memWdataNext_s;

  logic              pick_s, anyReq_s, advance_s, outOfRange_s;
  logic              selRw_s;
  logic [ADDR_W-1:0] selAddr_s;
  logic [DATA_W-1:0] selWdata_s;

  rr_arbiter2 uArb (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .advance    (advance_s),
    .servedPort (capPort_r),
    .pick       (pick_s),
    .anyReq     (anyReq_s)
  );

  assign selRw_s      = (pick_s == PORT1) ? rw1    : rw0;
  assign selAddr_s    = (pick_s == PORT1) ? addr1  : addr0;
  assign selWdata_s   = (pick_s == PORT1) ? wdata1 : wdata0;
  assign outOfRange_s = ({1'b0, selAddr_s} >= DEPTH_EXT);
  assign readVal_s    = (mem_rw == RW_WRITE) ? {DATA_W{1'b0}} : mem_rdata;

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    stateNext_s     = state_r;
    latCntNext_s    = latCnt_r;
    capPortNext_s   = capPort_r;
    capErrNext_s    = capErr_r;
    gnt0Next_s      = 1'b0;
    gnt1Next_s      = 1'b0;
    done0Next_s     = 1'b0;
    done1Next_s     = 1'b0;
    err0Next_s      = err0;
    err1Next_s      = err1;
    rdata0Next_s    = rdata0;
    rdata1Next_s    = rdata1;
    memActiveNext_s = 1'b0;
    memRwNext_s     = mem_rw;
    memIndexNext_s  = mem_index;
    memWdataNext_s  = mem_wdata;
    advance_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (anyReq_s) begin
          capPortNext_s = pick_s;
          if (pick_s == PORT1) begin
            gnt1Next_s = 1'b1;
          end else begin
            gnt0Next_s = 1'b1;
          end
          if (outOfRange_s) begin
            // Bad index: skip the memory entirely, report from DONE.
            capErrNext_s = 1'b1;
            stateNext_s  = DONE;
          end else begin
            capErrNext_s    = 1'b0;
            stateNext_s     = ACCESS;
            memActiveNext_s = 1'b1;
            memRwNext_s     = selRw_s;
            memIndexNext_s  = selAddr_s;
            memWdataNext_s  = selWdata_s;
            latCntNext_s    = LAT_LOAD;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      ACCESS: begin
        if (latCnt_r == 3'd0) begin
          stateNext_s = DONE;
          if (capPort_r == PORT1) begin
            done1Next_s  = 1'b1;
            err1Next_s   = 1'b0;
            rdata1Next_s = readVal_s;
          end else begin
            done0Next_s  = 1'b1;
            err0Next_s   = 1'b0;
            rdata0Next_s = readVal_s;
          end
        end else begin
          latCntNext_s    = latCnt_r - 3'd1;
          memActiveNext_s = 1'b1;
        end
      end
      DONE: begin
        advance_s   = 1'b1;
        stateNext_s = IDLE;
        if (capErr_r) begin
          // Error completion is reported one cycle after the grant.
          if (capPort_r == PORT1) begin
            done1Next_s  = 1'b1;
            err1Next_s   = 1'b1;
            rdata1Next_s = {DATA_W{1'b0}};
          end else begin
            done0Next_s  = 1'b1;
            err0Next_s   = 1'b1;
            rdata0Next_s = {DATA_W{1'b0}};
          end
        end else begin
          capErrNext_s = 1'b0;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State, counter, capture and output registers; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      latCnt_r   <= 3'd0;
      capPort_r  <= PORT0;
      capErr_r   <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= {DATA_W{1'b0}};
      rdata1     <= {DATA_W{1'b0}};
      mem_active <= 1'b0;
      mem_rw     <= RW_READ;
      mem_index  <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      state_r    <= stateNext_s;
      latCnt_r   <= latCntNext_s;
      capPort_r  <= capPortNext_s;
      capErr_r   <= capErrNext_s;
      gnt0       <= gnt0Next_s;
      gnt1       <= gnt1Next_s;
      done0      <= done0Next_s;
      done1      <= done1Next_s;
      err0       <= err0Next_s;
      err1       <= err1Next_s;
      rdata0     <= rdata0Next_s;
      rdata1     <= rdata1Next_s;
      mem_active <= memActiveNext_s;
      mem_rw     <= memRwNext_s;
      mem_index  <= memIndexNext_s;
      mem_wdata  <= memWdataNext_s;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with a behavioural 512x32 memory. Expected completions are queued per port
// when a request is issued; a monitor pops and compares on every done pulse.
module tb_data_mem_arbiter;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          nChecks = 0;
  int          nFail = 0;

  logic [1:0]  rst, req0, rw0, req1, rw1;
  logic [1:0]  gnt0, done0, err0, gnt1, done1, err1, memActive, memRw;
  logic [31:0] addr0 [2];
  logic [31:0] wdata0 [2];
  logic [31:0] addr1 [2];
  logic [31:0] wdata1 [2];
  logic [31:0] rdata0 [2];
  logic [31:0] rdata1 [2];
  logic [31:0] memIndex [2];
  logic [31:0] memWdata [2];

  exp_t        expQ [4][$];
  int          gntPort [2][$];
  int          gntCyc [2][$];
  int          doneCyc [2][$];

  logic        monDn, monEr;
  logic [31:0] monRd;
  exp_t        monE;

  always #5 clk = ~clk;

  // Cycle counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memInit(input int i);
    return 32'hA5A5_0000 ^ 32'(i);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [512];
    logic [31:0] memRd;

    initial begin
      for (int i = 0; i < 512; i++) mem[i] = memInit(i);
    end

    // Behavioural memory: synchronous write, combinational read.
    always @(posedge clk) begin
      if (memActive[g] && memRw[g] && (memIndex[g] < 32'd512)) mem[memIndex[g][8:0]] <= memWdata[g];
    end

    assign memRd = (memIndex[g] < 32'd512) ? mem[memIndex[g][8:0]] : 32'hBAD0_BAD0;

    data_mem_arbiter #(.MEM_LAT(LAT)) uDut (
      .clk        (clk),
      .rst        (rst[g]),
      .req0       (req0[g]),
      .rw0        (rw0[g]),
      .addr0      (addr0[g]),
      .wdata0     (wdata0[g]),
      .gnt0       (gnt0[g]),
      .done0      (done0[g]),
      .rdata0     (rdata0[g]),
      .err0       (err0[g]),
      .req1       (req1[g]),
      .rw1        (rw1[g]),
      .addr1      (addr1[g]),
      .wdata1     (wdata1[g]),
      .gnt1       (gnt1[g]),
      .done1      (done1[g]),
      .rdata1     (rdata1[g]),
      .err1       (err1[g]),
      .mem_active (memActive[g]),
      .mem_rw     (memRw[g]),
      .mem_index  (memIndex[g]),
      .mem_wdata  (memWdata[g]),
      .mem_rdata  (memRd)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: log grants/dones and score every completion against the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (gnt0[d]) begin gntPort[d].push_back(0); gntCyc[d].push_back(cyc); end
      if (gnt1[d]) begin gntPort[d].push_back(1); gntCyc[d].push_back(cyc); end
      if (memActive[d]) check("mem_index_in_range", 32'(memIndex[d] < 32'd512), 32'd1);
      for (int p = 0; p < 2; p++) begin
        monDn = (p == 0) ? done0[d] : done1[d];
        monRd = (p == 0) ? rdata0[d] : rdata1[d];
        monEr = (p == 0) ? err0[d] : err1[d];
        if (monDn) begin
          doneCyc[d].push_back(cyc);
          if (expQ[d*2+p].size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL unexpected_done dut%0d port%0d: got done with no pending request, required none", d, p);
          end else begin
            monE = expQ[d*2+p].pop_front();
            check($sformatf("rdata dut%0d port%0d", d, p), monRd, monE.rdata);
            check($sformatf("err dut%0d port%0d", d, p), 32'(monEr), 32'(monE.err));
          end
        end
      end
    end
  end

  task automatic drive(input int d, input int p, input logic req, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      rw0[d] = rw; addr0[d] = addr; wdata0[d] = wd; req0[d] = req;
    end else begin
      rw1[d] = rw; addr1[d] = addr; wdata1[d] = wd; req1[d] = req;
    end
  endtask

  // Queue the expected result, hold the request until granted (bounded).
  task automatic issue(input int d, input int p, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] expRd, input logic expErr,
                       output int lat);
    exp_t e;
    logic seen;
    e.rdata = expRd;
    e.err   = expErr;
    expQ[d*2+p].push_back(e);
    drive(d, p, 1'b1, rw, addr, wd);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      seen = (p == 0) ? gnt0[d] : gnt1[d];
    end
    if (!seen) begin
      nChecks++;
      nFail++;
      $display("FAIL grant_timeout dut%0d port%0d: no gnt after %0d cycles, required a gnt", d, p, lat);
    end
    drive(d, p, 1'b0, rw, addr, wd);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((expQ[2*d].size() + expQ[2*d+1].size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain dut%0d pending", d), 32'(expQ[2*d].size() + expQ[2*d+1].size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic clearLogs(input int d);
    gntPort[d].delete();
    gntCyc[d].delete();
    doneCyc[d].delete();
  endtask

  initial begin
    int lat;
    int n;
    logic seen;
    rst = 2'b11; req0 = 2'b00; req1 = 2'b00; rw0 = 2'b00; rw1 = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr0[d] = 32'd0; wdata0[d] = 32'd0; addr1[d] = 32'd0; wdata1[d] = 32'd0;
    end

    // Test 1: reset held 3 cycles with req0 high on dut0.
    drive(0, 0, 1'b1, RD, 32'd7, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t1_rst_gnt0", 32'(gnt0[0]), 32'd0);
      check("t1_rst_done0", 32'(done0[0]), 32'd0);
      check("t1_rst_mem_active", 32'(memActive[0]), 32'd0);
      check("t1_rst_rdata0", rdata0[0], 32'd0);
      check("t1_rst_mem_index", memIndex[0], 32'd0);
    end
    expQ[0].push_back('{memInit(7), 1'b0});
    rst = 2'b00;
    @(negedge clk);
    check("t1_gnt0_2nd_cycle", 32'(gnt0[0]), 32'd1);
    check("t1_mem_active", 32'(memActive[0]), 32'd1);
    req0[0] = 1'b0;
    @(negedge clk);
    check("t1_done0_3rd_cycle", 32'(done0[0]), 32'd1);
    @(negedge clk);

    // Test 2: write 0xDEADBEEF to word 5, read it back.
    issue(0, 0, WR, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, lat);
    check("t2_wr_gnt_lat", 32'(lat), 32'd1);
    @(negedge clk);
    check("t2_wr_done", 32'(done0[0]), 32'd1);
    @(negedge clk);
    issue(0, 0, RD, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, lat);
    check("t2_rd_gnt_lat", 32'(lat), 32'd1);
    @(negedge clk);
    check("t2_rd_done", 32'(done0[0]), 32'd1);
    @(negedge clk);

    // Test 4: port1 out-of-range index, then the last legal word.
    issue(0, 1, RD, 32'd512, 32'd0, 32'd0, 1'b1, lat);
    check("t4_err_gnt_lat", 32'(lat), 32'd1);
    check("t4_err_mem_active_gnt", 32'(memActive[0]), 32'd0);
    @(negedge clk);
    check("t4_err_done1", 32'(done1[0]), 32'd1);
    check("t4_err_mem_active_done", 32'(memActive[0]), 32'd0);
    issue(0, 1, RD, 32'd511, 32'd0, memInit(511), 1'b0, lat);
    check("t4_ok_gnt_lat", 32'(lat), 32'd1);
    check("t4_ok_mem_active", 32'(memActive[0]), 32'd1);
    check("t4_ok_mem_index", memIndex[0], 32'd511);
    drain(0);

    // Test 3: both ports contend for four reads; pointer now favours port 0.
    clearLogs(0);
    fork
      begin
        issue(0, 0, RD, 32'd20, 32'd0, memInit(20), 1'b0, lat);
        issue(0, 0, RD, 32'd22, 32'd0, memInit(22), 1'b0, lat);
      end
      begin
        issue(0, 1, RD, 32'd21, 32'd0, memInit(21), 1'b0, n);
        issue(0, 1, RD, 32'd23, 32'd0, memInit(23), 1'b0, n);
      end
    join
    drain(0);
    check("t3_gnt_count", 32'(gntPort[0].size()), 32'd4);
    if (gntPort[0].size() == 4 && doneCyc[0].size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("t3_gnt_order_%0d", k), 32'(gntPort[0][k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) begin
        check($sformatf("t3_gnt_spacing_%0d", k), 32'(gntCyc[0][k] - gntCyc[0][k-1]), 32'd3);
        check($sformatf("t3_done_before_gnt_%0d", k), 32'(doneCyc[0][k-1] < gntCyc[0][k]), 32'd1);
      end
    end

    // Test 5 (MEM_LAT=3): complete one port0 read, then abort the next with reset.
    issue(1, 0, RD, 32'd30, 32'd0, memInit(30), 1'b0, lat);
    check("t5_gnt_lat", 32'(lat), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_done_lat3", 32'(done0[1]), 32'd1);
    @(negedge clk);
    drive(1, 0, 1'b1, RD, 32'd31, 32'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = gnt0[1];
    end
    check("t5_abort_gnt", 32'(seen), 32'd1);
    drive(1, 0, 1'b0, RD, 32'd31, 32'd0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    check("t5_rst_mem_active", 32'(memActive[1]), 32'd0);
    check("t5_rst_rdata0", rdata0[1], 32'd0);
    rst[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_done_after_abort", 32'(done0[1]), 32'd0);
    end
    clearLogs(1);
    fork
      issue(1, 0, RD, 32'd32, 32'd0, memInit(32), 1'b0, lat);
      issue(1, 1, RD, 32'd33, 32'd0, memInit(33), 1'b0, n);
    join
    drain(1);
    check("t5_rr_reset_port0_first", 32'(gntPort[1].size() > 0 ? gntPort[1][0] : 9), 32'd0);

    // Test 6 (MEM_LAT=3): port1 streams four reads, port0 joins mid-stream.
    clearLogs(1);
    fork
      begin
        for (int k = 0; k < 4; k++) issue(1, 1, RD, 32'(40 + k), 32'd0, memInit(40 + k), 1'b0, n);
      end
      begin
        repeat (7) @(negedge clk);
        issue(1, 0, RD, 32'd50, 32'd0, memInit(50), 1'b0, lat);
      end
    join
    drain(1);
    check("t6_gnt_count", 32'(gntPort[1].size()), 32'd5);
    if (gntPort[1].size() == 5 && doneCyc[1].size() == 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("t6_gnt_order_%0d", k), 32'(gntPort[1][k]), (k == 2) ? 32'd0 : 32'd1);
      for (int k = 1; k < 5; k++) check($sformatf("t6_done_spacing_%0d", k), 32'(doneCyc[1][k] - doneCyc[1][k-1]), 32'd5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Watchdog: the run must end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
